// File: rtl/mem_arbiter.sv
// Purpose: arbitrates instruction-fetch and data-memory requests onto one shared memory bus; data wins ties.
// Latency: grant one edge after the request, ack_o one edge after bus_ack_i (minimum 2 cycles); abort after TIMEOUT silent bus cycles.
// Backpressure: one transaction in flight; stallreq_o holds the pipeline while any request is still unacknowledged.
// Ports: clk/rst (async active-low); if_* fetch side (read only); dm_* data side (read/write with byte selects);
//        bus_* shared memory port (request fields latched at grant); stallreq_o combinational stall request.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    output logic        if_err_o,
    // data memory
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_sel_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        dm_err_o,
    // shared memory bus
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    // stall controller
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q;
    logic       grant_dm, grant_if, done, abort;

    // A requester whose ack_o is high this cycle is still holding the request
    // it was just served for, so it is skipped to avoid a duplicate transaction.
    always_comb begin
        state_d  = state_q;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_req_i && !dm_ack_o) begin
                    grant_dm = 1'b1;
                    state_d  = DM_BUSY;
                end else if (if_req_i && !if_ack_o) begin
                    grant_if = 1'b1;
                    state_d  = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                // a late ack on the expiry edge still counts as success
                if (bus_ack_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= 8'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'd0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            if_data_o   <= 32'd0;
            if_ack_o    <= 1'b0;
            if_err_o    <= 1'b0;
            dm_rdata_o  <= 32'd0;
            dm_ack_o    <= 1'b0;
            dm_err_o    <= 1'b0;
        end else begin
            // completion flags are single-cycle pulses
            if_ack_o <= 1'b0;
            if_err_o <= 1'b0;
            dm_ack_o <= 1'b0;
            dm_err_o <= 1'b0;

            if (grant_dm) begin
                cnt_q       <= 8'd0;
                bus_req_o   <= 1'b1;
                bus_we_o    <= dm_we_i;
                bus_sel_o   <= dm_sel_i;
                bus_addr_o  <= dm_addr_i;
                bus_wdata_o <= dm_wdata_i;
            end else if (grant_if) begin
                cnt_q       <= 8'd0;
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_sel_o   <= 4'b1111;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= 32'd0;
            end else if (done) begin
                bus_req_o <= 1'b0;
                if (state_q == IF_BUSY) begin
                    if_data_o <= bus_rdata_i;
                    if_ack_o  <= 1'b1;
                end else begin
                    dm_ack_o <= 1'b1;
                    if (!bus_we_o) begin
                        dm_rdata_o <= bus_rdata_i;
                    end
                end
            end else if (abort) begin
                bus_req_o <= 1'b0;
                if (state_q == IF_BUSY) begin
                    if_data_o <= 32'd0;
                    if_ack_o  <= 1'b1;
                    if_err_o  <= 1'b1;
                end else begin
                    dm_rdata_o <= 32'd0;
                    dm_ack_o   <= 1'b1;
                    dm_err_o   <= 1'b1;
                end
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign stallreq_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = 32'd0;
    logic [31:0] if_data_o;
    logic        if_ack_o, if_err_o;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [3:0]  dm_sel_i = 4'd0;
    logic [31:0] dm_addr_i = 32'd0;
    logic [31:0] dm_wdata_i = 32'd0;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o, dm_err_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [31:0] bus_rdata_i = 32'd0;
    logic        bus_ack_i = 1'b0;
    logic        stallreq_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_data_o(if_data_o), .if_ack_o(if_ack_o), .if_err_o(if_err_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        #2 rst = 1'b0;
        #1;
        outs = {26'd0, bus_req_o, if_ack_o, dm_ack_o, if_err_o, dm_err_o, stallreq_o};
        total_cnt++;
        if (outs !== 32'd0) $display("FAIL reset_flags: got %h expected %h", outs, 32'd0);
        else pass_cnt++;
        total_cnt++;
        if ((if_data_o | dm_rdata_o | bus_addr_o | bus_wdata_o) !== 32'd0)
            $display("FAIL reset_data: got %h/%h/%h/%h expected 0", if_data_o, dm_rdata_o, bus_addr_o, bus_wdata_o);
        else pass_cnt++;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        tick();
        if_addr_i = 32'h999;  // post-grant change must not reach the bus
        #1;
        total_cnt++;
        if ({bus_req_o, bus_we_o, bus_sel_o, stallreq_o} !== 7'b1011111)
            $display("FAIL if_grant_ctrl: got %b expected %b", {bus_req_o, bus_we_o, bus_sel_o, stallreq_o}, 7'b1011111);
        else pass_cnt++;
        total_cnt++;
        if (bus_addr_o !== 32'h100) $display("FAIL if_grant_addr: got %h expected %h", bus_addr_o, 32'h100);
        else pass_cnt++;
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3C010001;
        tick();
        total_cnt++;
        if (if_data_o !== 32'h3C010001) $display("FAIL if_read_data: got %h expected %h", if_data_o, 32'h3C010001);
        else pass_cnt++;
        total_cnt++;
        if ({if_ack_o, if_err_o, bus_req_o, stallreq_o} !== 4'b1000)
            $display("FAIL if_read_ack: got %b expected %b", {if_ack_o, if_err_o, bus_req_o, stallreq_o}, 4'b1000);
        else pass_cnt++;
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        total_cnt++;
        if ({if_ack_o, bus_req_o} !== 2'b00) $display("FAIL if_ack_single: got %b expected %b", {if_ack_o, bus_req_o}, 2'b00);
        else pass_cnt++;
    endtask

    task automatic test_ack_vs_timeout();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h300;
        tick();
        for (int i = 0; i < 15; i++) tick();
        total_cnt++;
        if ({bus_req_o, dm_ack_o} !== 2'b10) $display("FAIL race_still_busy: got %b expected %b", {bus_req_o, dm_ack_o}, 2'b10);
        else pass_cnt++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFE0001;
        tick();
        total_cnt++;
        if ({dm_ack_o, dm_err_o, bus_req_o} !== 3'b100)
            $display("FAIL race_ack_wins: got %b expected %b", {dm_ack_o, dm_err_o, bus_req_o}, 3'b100);
        else pass_cnt++;
        total_cnt++;
        if (dm_rdata_o !== 32'hCAFE0001) $display("FAIL race_data: got %h expected %h", dm_rdata_o, 32'hCAFE0001);
        else pass_cnt++;
        dm_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        if_req_i = 1'b1; if_addr_i = 32'h40;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011;
        dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF;
        tick();
        total_cnt++;
        if ({bus_req_o, bus_we_o, bus_sel_o, stallreq_o} !== 7'b1100111)
            $display("FAIL prio_dm_ctrl: got %b expected %b", {bus_req_o, bus_we_o, bus_sel_o, stallreq_o}, 7'b1100111);
        else pass_cnt++;
        total_cnt++;
        if ({bus_addr_o, bus_wdata_o} !== {32'h200, 32'hDEADBEEF})
            $display("FAIL prio_dm_addr_wdata: got %h %h expected 00000200 deadbeef", bus_addr_o, bus_wdata_o);
        else pass_cnt++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h55555555;
        tick();
        total_cnt++;
        if ({dm_ack_o, bus_req_o, stallreq_o, if_ack_o} !== 4'b1010)
            $display("FAIL prio_dm_done: got %b expected %b", {dm_ack_o, bus_req_o, stallreq_o, if_ack_o}, 4'b1010);
        else pass_cnt++;
        total_cnt++;
        if (dm_rdata_o !== 32'hCAFE0001) $display("FAIL write_keeps_rdata: got %h expected %h", dm_rdata_o, 32'hCAFE0001);
        else pass_cnt++;
        dm_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        total_cnt++;
        if ({bus_req_o, bus_we_o, bus_sel_o, stallreq_o, dm_ack_o} !== 8'b10111110)
            $display("FAIL prio_if_ctrl: got %b expected %b", {bus_req_o, bus_we_o, bus_sel_o, stallreq_o, dm_ack_o}, 8'b10111110);
        else pass_cnt++;
        total_cnt++;
        if ({bus_addr_o, bus_wdata_o} !== {32'h40, 32'h0})
            $display("FAIL prio_if_addr_wdata: got %h %h expected 00000040 00000000", bus_addr_o, bus_wdata_o);
        else pass_cnt++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
        tick();
        total_cnt++;
        if ({if_ack_o, if_data_o, stallreq_o} !== {1'b1, 32'h12345678, 1'b0})
            $display("FAIL prio_if_done: got %b %h %b expected 1 12345678 0", if_ack_o, if_data_o, stallreq_o);
        else pass_cnt++;
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        bit seen;
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h400;
        tick();
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            n++;
            if (dm_ack_o) seen = 1'b1;
        end
        total_cnt++;
        if (!seen || n != 16) $display("FAIL timeout_cycles: got %0d (seen=%0d) expected 16", n, seen);
        else pass_cnt++;
        total_cnt++;
        if ({dm_ack_o, dm_err_o, bus_req_o} !== 3'b110)
            $display("FAIL timeout_flags: got %b expected %b", {dm_ack_o, dm_err_o, bus_req_o}, 3'b110);
        else pass_cnt++;
        total_cnt++;
        if (dm_rdata_o !== 32'd0) $display("FAIL timeout_data: got %h expected %h", dm_rdata_o, 32'd0);
        else pass_cnt++;
        dm_req_i = 1'b0;
        tick();
        total_cnt++;
        if ({dm_ack_o, dm_err_o} !== 2'b00) $display("FAIL timeout_pulse: got %b expected %b", {dm_ack_o, dm_err_o}, 2'b00);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500;
        tick();
        total_cnt++;
        if (bus_req_o !== 1'b1) $display("FAIL rmid_granted: got %b expected %b", bus_req_o, 1'b1);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus_req_o, dm_ack_o} !== 2'b00) $display("FAIL rmid_async_drop: got %b expected %b", {bus_req_o, dm_ack_o}, 2'b00);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if ({bus_req_o, dm_ack_o} !== 2'b00) $display("FAIL rmid_held: got %b expected %b", {bus_req_o, dm_ack_o}, 2'b00);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({bus_req_o, bus_addr_o} !== {1'b1, 32'h500})
            $display("FAIL rmid_regrant: got %b %h expected 1 00000500", bus_req_o, bus_addr_o);
        else pass_cnt++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        tick();
        dm_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus_ack_i = 1'b1;
        tick();
        total_cnt++;
        if ({if_ack_o, dm_ack_o, bus_req_o} !== 3'b000)
            $display("FAIL spurious_ack: got %b expected %b", {if_ack_o, dm_ack_o, bus_req_o}, 3'b000);
        else pass_cnt++;
        bus_ack_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h600;
        tick();
        bus_ack_i = 1'b1; bus_rdata_i = 32'h11112222;
        tick();
        total_cnt++;
        if ({if_ack_o, bus_req_o} !== 2'b10) $display("FAIL held_first_ack: got %b expected %b", {if_ack_o, bus_req_o}, 2'b10);
        else pass_cnt++;
        bus_ack_i = 1'b0;
        tick();
        total_cnt++;
        if ({if_ack_o, bus_req_o} !== 2'b00) $display("FAIL held_no_dup: got %b expected %b", {if_ack_o, bus_req_o}, 2'b00);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus_req_o !== 1'b1) $display("FAIL held_new_txn: got %b expected %b", bus_req_o, 1'b1);
        else pass_cnt++;
        if_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h33334444;
        tick();
        total_cnt++;
        if ({if_ack_o, if_data_o} !== {1'b1, 32'h33334444})
            $display("FAIL held_second_ack: got %b %h expected 1 33334444", if_ack_o, if_data_o);
        else pass_cnt++;
        bus_ack_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_ack_vs_timeout();
        test_priority();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, 16, bus cycles without bus_ack_i before a transaction is aborted (range 2..255).
REQ-002 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports if_req_i in 1, if_addr_i in 32: instruction-fetch read request and word address.
REQ-005 SHALL have ports if_data_o out 32, if_ack_o out 1, if_err_o out 1: fetch read data, completion pulse, timeout flag.
REQ-006 SHALL have ports dm_req_i in 1, dm_we_i in 1, dm_sel_i in 4, dm_addr_i in 32, dm_wdata_i in 32: data-memory request, write enable, byte selects, address, write data.
REQ-007 SHALL have ports dm_rdata_o out 32, dm_ack_o out 1, dm_err_o out 1: data read result, completion pulse, timeout flag.
REQ-008 SHALL have ports bus_req_o out 1, bus_we_o out 1, bus_sel_o out 4, bus_addr_o out 32, bus_wdata_o out 32: shared memory port request side.
REQ-009 SHALL have ports bus_rdata_i in 32, bus_ack_i in 1: shared memory port response side.
REQ-010 SHALL have port stallreq_o  out  1  pipeline stall request to the stall controller.

Function
REQ-011 SHALL implement states IDLE, IF_BUSY, DM_BUSY.
REQ-012 IDLE: dm_req_i high and dm_ack_o low -> DM_BUSY; else if_req_i high and if_ack_o low -> IF_BUSY; else stay (data priority over fetch).
REQ-013 On the grant edge SHALL latch the winner's addr/we/sel/wdata; bus_* outputs SHALL be driven only from these latches, stable for the whole transaction; IF grant: bus_we_o=0, bus_sel_o=4'b1111, bus_wdata_o=0.
REQ-014 bus_req_o SHALL be registered, high exactly while in IF_BUSY or DM_BUSY.
REQ-015 In a BUSY state, bus_ack_i high at a rising edge SHALL: capture bus_rdata_i into if_data_o (IF) or dm_rdata_o (DM read only), pulse the matching ack_o high for exactly one cycle, clear bus_req_o, return to IDLE.
REQ-016 DM write completion SHALL leave dm_rdata_o unchanged.
REQ-017 Latency: request sampled at edge N -> bus_req_o high from N+1; bus_ack_i sampled at edge M -> ack_o high in cycle after M; minimum 2 cycles request to ack_o.
REQ-018 A requester whose ack_o is high in the current cycle SHALL NOT be granted in that cycle (no duplicate service from a held request).
REQ-019 Timeout counter (8 bit) SHALL clear on grant, increment each BUSY cycle without bus_ack_i; on reaching TIMEOUT-1 SHALL abort: bus_req_o low, matching ack_o and err_o pulse together one cycle, data output set to 0, return to IDLE.
REQ-020 bus_ack_i in the same cycle as timeout expiry SHALL win: normal completion, err_o stays 0.
REQ-021 bus_ack_i while in IDLE SHALL be ignored.
REQ-022 Requester deasserting req mid-transaction SHALL NOT abort; bus transaction completes and ack_o still pulses.
REQ-023 Input changes of the granted requester after grant SHALL NOT affect bus_* outputs.
REQ-024 stallreq_o SHALL be combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
REQ-025 Only one transaction outstanding at any time; IDLE occupies at least one cycle between transactions.

Reset
REQ-026 rst low SHALL immediately (asynchronously) force state IDLE, counter 0, all registered outputs 0 including bus_req_o, if_ack_o, dm_ack_o, err flags, data outputs.
REQ-027 Reset mid-transaction SHALL drop the transaction with no ack_o pulse; after rst release arbitration restarts from IDLE on the first edge.

Verification
REQ-028 IF read: if_req_i=1, if_addr_i=0x100, bus_ack_i after 2 BUSY cycles with bus_rdata_i=0x3C010001 -> bus_addr_o=0x100, if_data_o=0x3C010001, single if_ack_o pulse.
REQ-029 Simultaneous if_req_i and dm_req_i (write, addr 0x200, sel 4'b0011, wdata 0xDEADBEEF) -> DM served first with bus_we_o=1, bus_sel_o=4'b0011, then IF granted after one IDLE cycle; stallreq_o high throughout until both acked.
REQ-030 Timeout: dm_req_i read, bus_ack_i never asserted, TIMEOUT=16 -> dm_ack_o and dm_err_o pulse together 16 cycles after grant, dm_rdata_o=0, bus_req_o low.
REQ-031 bus_ack_i coincident with timeout expiry -> normal completion, dm_err_o=0, read data captured.
REQ-032 rst asserted low in DM_BUSY -> bus_req_o drops without clock edge, no dm_ack_o; held dm_req_i re-granted first cycle after release.
REQ-033 Held if_req_i across its ack_o cycle -> exactly one bus transaction per pulse; spurious bus_ack_i in IDLE -> no ack_o.
